// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration stream loader: FSM state codes,
// framing defaults, bus widths and the 64-bit record layout.
package cfg_pkg;
    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;
    localparam int TILE_ID_W  = 16;
    localparam int REC_BYTES  = 8;

    // Record layout: addr occupies the upper half; tile field is addr[31:16]
    localparam int REC_ADDR_LSB = CFG_DATA_W;
    localparam int TILE_LSB     = CFG_ADDR_W - TILE_ID_W;

    localparam logic [7:0]            SYNC_BYTE_DEF = 8'hA5;
    localparam logic [CFG_ADDR_W-1:0] IDLE_ADDR_DEF = 32'hFFFF_FFFF;

    localparam logic [2:0] ST_HUNT     = 3'd0;
    localparam logic [2:0] ST_COUNT_HI = 3'd1;
    localparam logic [2:0] ST_COUNT_LO = 3'd2;
    localparam logic [2:0] ST_REC      = 3'd3;
    localparam logic [2:0] ST_CHK      = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_ERR      = 3'd6;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_rec_t;
endpackage

// File: rtl/cfg_rec_assembler.sv
// Byte-to-record assembler: big-endian 64-bit shift register, byte index,
// running XOR checksum and the one-cycle issue pulse.
module cfg_rec_assembler
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       byte_en,
    input  logic [7:0] byte_in,
    output logic       last_byte,
    output logic       issue,
    output cfg_rec_t   rec,
    output logic [7:0] chk
);
    logic [2:0]                 idx;
    logic [8*REC_BYTES-1:0]     sr;

    assign last_byte = byte_en && (idx == 3'(REC_BYTES - 1));
    assign rec       = cfg_rec_t'(sr);

    // The shift register still holds the completed record during the issue
    // cycle; the next record's first byte only lands at the end of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            sr    <= '0;
            chk   <= '0;
            issue <= 1'b0;
        end else begin
            issue <= last_byte;
            if (byte_en) begin
                idx <= idx + 3'd1;
                sr  <= {sr[8*REC_BYTES-9:0], byte_in};
                chk <= chk ^ byte_in;
            end else if (clr) begin
                chk <= '0;
            end
        end
    end
endmodule

// File: rtl/cfg_stream_loader.sv
// Framed byte stream to PE config bus loader with checksum status.
// Optional record counter port enabled by CFG_LOADER_STATS_EN.
module cfg_stream_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0]            SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [CFG_ADDR_W-1:0] IDLE_ADDR = IDLE_ADDR_DEF,
    parameter int                    CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clr,
    output logic [CFG_ADDR_W-1:0] config_addr,
    output logic [CFG_DATA_W-1:0] config_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef CFG_LOADER_STATS_EN
    ,
    output logic [CNT_W-1:0]      rec_count
`endif
);
    logic [2:0]       state, state_nxt;
    logic [7:0]       cnt_hi;
    logic [CNT_W-1:0] remaining;
    logic             acc, rec_en, clr_eff, last_byte, issue, sync_hit;
    logic [7:0]       chk;
    cfg_rec_t         rec;

    assign acc      = in_valid && in_ready;
    assign rec_en   = acc && (state == ST_REC);
    assign clr_eff  = clr && ((state == ST_DONE) || (state == ST_ERR));
    assign sync_hit = acc && (state == ST_HUNT) && (in_data == SYNC_BYTE);

    cfg_rec_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr_eff),
        .byte_en   (rec_en),
        .byte_in   (in_data),
        .last_byte (last_byte),
        .issue     (issue),
        .rec       (rec),
        .chk       (chk)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT:     if (sync_hit) state_nxt = ST_COUNT_HI;
            ST_COUNT_HI: if (acc) state_nxt = ST_COUNT_LO;
            ST_COUNT_LO: if (acc) state_nxt = ({cnt_hi, in_data} == 16'h0) ? ST_CHK : ST_REC;
            ST_REC:      if (last_byte && remaining == CNT_W'(1)) state_nxt = ST_CHK;
            ST_CHK:      if (acc) state_nxt = (in_data == chk) ? ST_DONE : ST_ERR;
            ST_DONE,
            ST_ERR:      if (clr) state_nxt = ST_HUNT;
            default:     state_nxt = ST_HUNT;
        endcase
    end

    // in_ready is registered from the next state so it is low during reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HUNT;
            in_ready  <= 1'b0;
            cnt_hi    <= '0;
            remaining <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_DONE) && (state_nxt != ST_ERR);
            if (acc && state == ST_COUNT_HI) cnt_hi <= in_data;
            if (acc && state == ST_COUNT_LO) remaining <= CNT_W'({cnt_hi, in_data});
            else if (last_byte)              remaining <= remaining - CNT_W'(1);
        end
    end

    assign busy        = (state == ST_COUNT_HI) || (state == ST_COUNT_LO) ||
                         (state == ST_REC) || (state == ST_CHK);
    assign done        = (state == ST_DONE);
    assign err         = (state == ST_ERR);
    assign config_addr = issue ? rec.addr : IDLE_ADDR;
    assign config_data = issue ? rec.data : '0;

`ifdef CFG_LOADER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      rec_count <= '0;
        else if (clr_eff || sync_hit)    rec_count <= '0;
        else if (issue && !(&rec_count)) rec_count <= rec_count + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed plus randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_cfg_stream_loader;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic        clk = 1'b0, reset = 1'b0, clr = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        in_ready, busy, done, err;
    logic [31:0] config_addr, config_data;
`ifdef CFG_LOADER_STATS_EN
    logic [15:0] rec_count;
`endif

    int nerr = 0, nchk = 0;

    always #5 clk = ~clk;

    cfg_stream_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .clr         (clr),
        .config_addr (config_addr),
        .config_data (config_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef CFG_LOADER_STATS_EN
        ,
        .rec_count   (rec_count)
`endif
    );

    // Bus observer: every non-idle cycle is logged with its cycle number
    int          cyc = 0, bad_idle = 0;
    logic [31:0] oa[$], od[$];
    int          oc[$];
    always @(negedge clk) begin
        cyc++;
        if (config_addr !== IDLE) begin
            oa.push_back(config_addr);
            od.push_back(config_data);
            oc.push_back(cyc);
        end else if (config_data !== 32'h0) begin
            bad_idle++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    // Reference model: expected records and the byte frame built from them
    logic [31:0] ea[$], ed[$];
    logic [7:0]  frm[$];

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        nchk++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic build(input logic [7:0] flip);
        logic [7:0]  x;
        logic [15:0] n;
        logic [63:0] r;
        x = 8'h0;
        n = 16'(ea.size());
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(n[15:8]);
        frm.push_back(n[7:0]);
        for (int i = 0; i < ea.size(); i++) begin
            r = {ea[i], ed[i]};
            for (int b = 7; b >= 0; b--) begin
                frm.push_back(r[b*8 +: 8]);
                x = x ^ r[b*8 +: 8];
            end
        end
        frm.push_back(x ^ flip);
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("ready_timeout", {63'h0, in_ready}, 64'h1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic send(input int lo, input int hi, input int gap, input bit rgap);
        for (int i = lo; i <= hi && i < frm.size(); i++)
            put(frm[i], rgap ? int'($urandom_range(0, 2)) : gap);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic cmp_recs(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_nrec"}, 64'(oa.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
            check({tag, "_addr"}, 64'(oa[i]), 64'(ea[i]));
            check({tag, "_data"}, 64'(od[i]), 64'(ed[i]));
        end
    endtask

    task automatic clear_obs();
        oa.delete(); od.delete(); oc.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {63'h0, in_ready}, 64'h0);
        check("rst_busy",  {63'h0, busy}, 64'h0);
        check("rst_done",  {62'h0, done, err}, 64'h0);
        check("rst_addr",  64'(config_addr), 64'(IDLE));
        check("rst_data",  64'(config_data), 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("hunt_ready", {63'h0, in_ready}, 64'h1);

        // Single record
        clear_obs();
        ea = '{32'h0005_0002}; ed = '{32'hDEAD_BEEF};
        build(8'h00);
        send(0, 0, 0, 0);
        @(negedge clk);
        check("busy_after_sync", {63'h0, busy}, 64'h1);
        send(1, frm.size() - 1, 0, 0);
        cmp_recs("single");
        check("single_done", {60'h0, done, err, busy, in_ready}, 64'h8);

        // Two back-to-back records
        pulse_clr();
        clear_obs();
        bad_idle = 0;
        ea = '{32'h0001_0000, 32'h0002_0000}; ed = '{32'h1111_1111, 32'h2222_2222};
        build(8'h00);
        send(0, frm.size() - 1, 0, 0);
        cmp_recs("b2b");
        check("b2b_spacing", (oc.size() == 2) ? 64'(oc[1] - oc[0]) : 64'hFFFF, 64'd8);
        check("b2b_idle", 64'(bad_idle), 64'h0);
        check("b2b_done", {62'h0, done, err}, 64'h2);

        // Bad checksum
        pulse_clr();
        clear_obs();
        ea = '{32'h0005_0002}; ed = '{32'hDEAD_BEEF};
        build(8'h01);
        send(0, frm.size() - 1, 0, 0);
        cmp_recs("badchk");
        check("badchk_err", {62'h0, done, err}, 64'h1);
        pulse_clr();
        @(negedge clk);
        check("clr_state", {60'h0, done, err, busy, in_ready}, 64'h1);

        // Leading junk, zero records
        clear_obs();
        ea.delete(); ed.delete();
        frm = '{8'h00, 8'h37, 8'hA5, 8'h00, 8'h00, 8'h00};
        send(0, frm.size() - 1, 0, 0);
        cmp_recs("zero");
        check("zero_done", {62'h0, done, err}, 64'h2);

        // Reset mid-record
        pulse_clr();
        clear_obs();
        ea = '{32'h0003_0010}; ed = '{32'hCAFE_F00D};
        build(8'h00);
        send(0, 7, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_outs", {60'h0, done, err, busy, in_ready}, 64'h0);
        check("mid_rst_addr", 64'(config_addr), 64'(IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_noissue", 64'(oa.size()), 64'h0);
        ea = '{32'h0004_0020}; ed = '{32'h1234_5678};
        build(8'h00);
        send(0, frm.size() - 1, 0, 0);
        cmp_recs("post_rst");
        check("post_rst_done", {62'h0, done, err}, 64'h2);

        // in_valid toggling every cycle
        pulse_clr();
        clear_obs();
        ea = '{32'h0005_0002}; ed = '{32'hDEAD_BEEF};
        build(8'h00);
        send(0, frm.size() - 1, 1, 0);
        cmp_recs("toggle");
        check("toggle_done", {62'h0, done, err}, 64'h2);
`ifdef CFG_LOADER_STATS_EN
        check("toggle_count", 64'(rec_count), 64'h1);
`endif

        // Randomized frames with embedded sync bytes and random gaps
        for (int f = 0; f < 4; f++) begin
            int n;
            pulse_clr();
            clear_obs();
            ea.delete(); ed.delete();
            n = $urandom_range(2, 5);
            for (int i = 0; i < n; i++) begin
                ea.push_back({16'($urandom_range(0, 16'hFFFE)), 16'($urandom)});
                ed.push_back($urandom);
            end
            ea[0][7:0] = 8'hA5;
            build(8'h00);
            send(0, frm.size() - 1, 0, 1);
            cmp_recs("rand");
            check("rand_done", {62'h0, done, err}, 64'h2);
`ifdef CFG_LOADER_STATS_EN
            check("rand_count", 64'(rec_count), 64'(n));
`endif
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
